// File: rtl/spi_master_core_if.sv
// Bus-side and SPI-side signal bundle for spi_master_core.
// The master modport is the core's view; the slave modport is the bus/pad side that drives requests and MISO.
interface spi_master_core_if;
  logic        enable_i;
  logic [31:0] spi_write_data_i;
  logic [2:0]  spi_write_data_bytes_valid_i;
  logic        spi_miso_i;
  logic        spi_mosi_o;
  logic        spi_clk_o;
  logic        spi_ss_o;
  logic [31:0] spi_read_data_o;
  logic [2:0]  spi_read_data_bytes_valid_o;

  modport master (
    input  enable_i,
    input  spi_write_data_i,
    input  spi_write_data_bytes_valid_i,
    input  spi_miso_i,
    output spi_mosi_o,
    output spi_clk_o,
    output spi_ss_o,
    output spi_read_data_o,
    output spi_read_data_bytes_valid_o
  );

  modport slave (
    output enable_i,
    output spi_write_data_i,
    output spi_write_data_bytes_valid_i,
    output spi_miso_i,
    input  spi_mosi_o,
    input  spi_clk_o,
    input  spi_ss_o,
    input  spi_read_data_o,
    input  spi_read_data_bytes_valid_o
  );
endinterface

// File: rtl/spi_master_core.sv
// SPI mode-0 master, MSB first: shifts 1-4 bytes out on MOSI while capturing the same count from MISO.
// All outputs are registered; the next-state/output logic lives in a single combinational process.
module spi_master_core #(
  parameter int unsigned CLK_DIV = 2
) (
  input logic              clk_i,
  input logic              rst_i,
  spi_master_core_if.master bus
);

  localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned NB_W   = 3;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t              state, state_nxt;
  logic [DIV_W-1:0]    div_cnt, div_cnt_nxt;
  logic [CNT_W-1:0]    bit_cnt, bit_cnt_nxt;
  logic [NB_W-1:0]     nbytes, nbytes_nxt;
  logic [DATA_W-1:0]   tx_sr, tx_sr_nxt;
  logic [DATA_W-1:0]   rx_sr, rx_sr_nxt;
  logic                sclk, sclk_nxt;
  logic                ss, ss_nxt;
  logic                mosi, mosi_nxt;
  logic [DATA_W-1:0]   rd_data, rd_data_nxt;
  logic [NB_W-1:0]     rd_bytes, rd_bytes_nxt;

  logic [NB_W-1:0]     req_bytes_c;
  logic [DATA_W-1:0]   tx_aligned_c;
  logic [CNT_W-1:0]    total_bits_c;
  logic                div_end_c;

  // Clamp the requested byte count to 4 and left-align the valid bytes so MOSI always comes from bit 31.
  always_comb begin
    req_bytes_c = (bus.spi_write_data_bytes_valid_i > NB_W'(4)) ? NB_W'(4)
                                                                : bus.spi_write_data_bytes_valid_i;
    case (req_bytes_c)
      NB_W'(1): tx_aligned_c = {bus.spi_write_data_i[7:0],  24'h000000};
      NB_W'(2): tx_aligned_c = {bus.spi_write_data_i[15:0], 16'h0000};
      NB_W'(3): tx_aligned_c = {bus.spi_write_data_i[23:0], 8'h00};
      default:  tx_aligned_c = bus.spi_write_data_i;
    endcase
  end

  assign total_bits_c = {nbytes, 3'b000};
  assign div_end_c    = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_comb begin
    state_nxt    = state;
    div_cnt_nxt  = div_cnt;
    bit_cnt_nxt  = bit_cnt;
    nbytes_nxt   = nbytes;
    tx_sr_nxt    = tx_sr;
    rx_sr_nxt    = rx_sr;
    sclk_nxt     = sclk;
    ss_nxt       = ss;
    mosi_nxt     = mosi;
    rd_data_nxt  = rd_data;
    rd_bytes_nxt = rd_bytes;

    case (state)
      IDLE: begin
        if (bus.enable_i && (req_bytes_c != NB_W'(0))) begin
          nbytes_nxt   = req_bytes_c;
          tx_sr_nxt    = tx_aligned_c;
          mosi_nxt     = tx_aligned_c[DATA_W-1];
          ss_nxt       = 1'b0;
          rd_bytes_nxt = NB_W'(0);
          rx_sr_nxt    = DATA_W'(0);
          div_cnt_nxt  = DIV_W'(0);
          bit_cnt_nxt  = CNT_W'(0);
          state_nxt    = SETUP;
        end
      end

      SETUP: begin
        if (div_end_c) begin
          div_cnt_nxt = DIV_W'(0);
          sclk_nxt    = 1'b1;
          rx_sr_nxt   = {rx_sr[DATA_W-2:0], bus.spi_miso_i};
          state_nxt   = SHIFT;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      // bit_cnt counts completed falling edges; the final low half-period runs out before HOLD.
      SHIFT: begin
        if (div_end_c) begin
          div_cnt_nxt = DIV_W'(0);
          if (!sclk) begin
            if (bit_cnt == total_bits_c) begin
              state_nxt = HOLD;
            end else begin
              sclk_nxt  = 1'b1;
              rx_sr_nxt = {rx_sr[DATA_W-2:0], bus.spi_miso_i};
            end
          end else begin
            sclk_nxt    = 1'b0;
            bit_cnt_nxt = bit_cnt + CNT_W'(1);
            if ((bit_cnt + CNT_W'(1)) != total_bits_c) begin
              tx_sr_nxt = tx_sr << 1;
              mosi_nxt  = tx_sr[DATA_W-2];
            end
          end
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      HOLD: begin
        if (div_end_c) begin
          div_cnt_nxt  = DIV_W'(0);
          ss_nxt       = 1'b1;
          mosi_nxt     = 1'b0;
          rd_data_nxt  = rx_sr;
          rd_bytes_nxt = nbytes;
          state_nxt    = DONE;
        end else begin
          div_cnt_nxt = div_cnt + DIV_W'(1);
        end
      end

      // A held request yields one transfer; re-arm only after enable drops.
      DONE: begin
        if (!bus.enable_i) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      div_cnt  <= DIV_W'(0);
      bit_cnt  <= CNT_W'(0);
      nbytes   <= NB_W'(0);
      tx_sr    <= DATA_W'(0);
      rx_sr    <= DATA_W'(0);
      sclk     <= 1'b0;
      ss       <= 1'b1;
      mosi     <= 1'b0;
      rd_data  <= DATA_W'(0);
      rd_bytes <= NB_W'(0);
    end else begin
      state    <= state_nxt;
      div_cnt  <= div_cnt_nxt;
      bit_cnt  <= bit_cnt_nxt;
      nbytes   <= nbytes_nxt;
      tx_sr    <= tx_sr_nxt;
      rx_sr    <= rx_sr_nxt;
      sclk     <= sclk_nxt;
      ss       <= ss_nxt;
      mosi     <= mosi_nxt;
      rd_data  <= rd_data_nxt;
      rd_bytes <= rd_bytes_nxt;
    end
  end

  assign bus.spi_mosi_o                  = mosi;
  assign bus.spi_clk_o                   = sclk;
  assign bus.spi_ss_o                    = ss;
  assign bus.spi_read_data_o             = rd_data;
  assign bus.spi_read_data_bytes_valid_o = rd_bytes;

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: transaction-level waveform model checked every cycle,
// plus literal expectations (pulse counts, SS-low length, MOSI byte patterns, read data).
module tb_spi_master_core;

  localparam int D = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   miso_mode = 1;   // 0: MISO=0, 1: MISO=1, 2: MISO looped back from MOSI

  always #10 clk = ~clk;

  spi_master_core_if bus();

  assign bus.spi_miso_i = (miso_mode == 2) ? bus.spi_mosi_o : (miso_mode == 1);

  spi_master_core #(.CLK_DIV(D)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.master)
  );

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Transaction-level model: phase 0 idle, 1 busy (k = edges since launch), 2 done.
  int          ph = 0;
  int          k = 0;
  int          m_n = 0;
  int          m_bits = 8;
  logic [31:0] m_tx = '0;
  logic [31:0] exp_rd = '0;
  int          exp_bv = 0;

  always @(posedge clk) begin
    int n_in;
    logic [63:0] mask;
    if (rst) begin
      ph = 0; k = 0; exp_rd = '0; exp_bv = 0;
    end else begin
      case (ph)
        0: begin
          n_in = int'(bus.spi_write_data_bytes_valid_i);
          if (bus.enable_i && n_in != 0) begin
            if (n_in > 4) n_in = 4;
            m_n    = n_in;
            m_bits = 8 * n_in;
            mask   = (64'd1 << m_bits) - 64'd1;
            m_tx   = bus.spi_write_data_i & mask[31:0];
            k      = 0;
            ph     = 1;
          end
        end
        1: begin
          k++;
          if (k == 2 * D * (m_bits + 1)) begin
            mask   = (64'd1 << m_bits) - 64'd1;
            ph     = 2;
            exp_bv = m_n;
            exp_rd = (miso_mode == 2) ? m_tx : (miso_mode == 1) ? mask[31:0] : 32'h0;
          end
        end
        default: if (!bus.enable_i) ph = 0;
      endcase
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    int b;
    logic e_sclk;
    if (ph == 1) begin
      e_sclk = (k >= D && k < D + 2 * D * m_bits) ? (((k - D) / D) % 2 == 0) : 1'b0;
      b = k / (2 * D);
      if (b > m_bits - 1) b = m_bits - 1;
      check("busy_ss",   32'(bus.spi_ss_o), 32'h0);
      check("busy_sclk", 32'(bus.spi_clk_o), 32'(e_sclk));
      check("busy_mosi", 32'(bus.spi_mosi_o), 32'(m_tx[m_bits - 1 - b]));
      check("busy_bv",   32'(bus.spi_read_data_bytes_valid_o), 32'h0);
    end else begin
      check("idle_ss",   32'(bus.spi_ss_o), 32'h1);
      check("idle_sclk", 32'(bus.spi_clk_o), 32'h0);
      check("idle_mosi", 32'(bus.spi_mosi_o), 32'h0);
      check("idle_bv",   32'(bus.spi_read_data_bytes_valid_o), 32'(exp_bv));
      check("idle_rd",   bus.spi_read_data_o, exp_rd);
    end
  end

  // Independent counters: SCLK rising edges, SS-low cycles, MOSI sampled at each SCLK rise.
  int          pulses = 0;
  int          ss_low = 0;
  logic [31:0] cap = '0;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (bus.spi_clk_o === 1'b1 && prev_sclk === 1'b0) begin
      pulses++;
      cap = {cap[30:0], bus.spi_mosi_o};
    end
    if (bus.spi_ss_o === 1'b0) ss_low++;
    prev_sclk = bus.spi_clk_o;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int p0, s0;
    bit hit;
    bus.enable_i = 1'b1;
    bus.spi_write_data_i = 32'h695A0FC3;
    bus.spi_write_data_bytes_valid_i = 3'd1;
    miso_mode = 1;

    // Reset held with enable high
    p0 = pulses;
    cycles(10);
    check("rst_pulses", 32'(pulses - p0), 32'd0);
    check("rst_ss", 32'(bus.spi_ss_o), 32'd1);
    check("rst_rd", bus.spi_read_data_o, 32'h0);
    check("rst_bv", 32'(bus.spi_read_data_bytes_valid_o), 32'd0);

    // One byte, MISO=1, enable held for 8000 ns
    p0 = pulses; s0 = ss_low;
    rst = 1'b0;
    cycles(400);
    check("b1_pulses", 32'(pulses - p0), 32'd8);
    check("b1_ss_low", 32'(ss_low - s0), 32'd36);
    check("b1_mosi", {24'h0, cap[7:0]}, 32'h000000C3);
    check("b1_rd", bus.spi_read_data_o, 32'h000000FF);
    check("b1_bv", 32'(bus.spi_read_data_bytes_valid_o), 32'd1);
    bus.enable_i = 1'b0;
    cycles(3);

    // Four-byte loopback
    miso_mode = 2;
    bus.spi_write_data_bytes_valid_i = 3'd4;
    p0 = pulses; s0 = ss_low;
    bus.enable_i = 1'b1;
    cycles(150);
    check("b4_pulses", 32'(pulses - p0), 32'd32);
    check("b4_ss_low", 32'(ss_low - s0), 32'd132);
    check("b4_mosi", cap, 32'h695A0FC3);
    check("b4_rd", bus.spi_read_data_o, 32'h695A0FC3);
    check("b4_bv", 32'(bus.spi_read_data_bytes_valid_o), 32'd4);
    bus.enable_i = 1'b0;
    cycles(3);

    // Re-trigger with two bytes, MISO=0
    miso_mode = 0;
    bus.spi_write_data_i = 32'h0000A55A;
    bus.spi_write_data_bytes_valid_i = 3'd2;
    p0 = pulses;
    bus.enable_i = 1'b1;
    cycles(90);
    check("b2_pulses", 32'(pulses - p0), 32'd16);
    check("b2_mosi", {16'h0, cap[15:0]}, 32'h0000A55A);
    check("b2_rd", bus.spi_read_data_o, 32'h0);
    check("b2_bv", 32'(bus.spi_read_data_bytes_valid_o), 32'd2);
    bus.enable_i = 1'b0;
    cycles(3);

    // N=0: no transfer, previous results persist
    bus.spi_write_data_bytes_valid_i = 3'd0;
    p0 = pulses; s0 = ss_low;
    bus.enable_i = 1'b1;
    cycles(20);
    check("n0_pulses", 32'(pulses - p0), 32'd0);
    check("n0_ss_low", 32'(ss_low - s0), 32'd0);
    check("n0_bv", 32'(bus.spi_read_data_bytes_valid_o), 32'd2);
    bus.enable_i = 1'b0;
    cycles(3);

    // N=7 clamps to 4, loopback
    miso_mode = 2;
    bus.spi_write_data_i = 32'h12345678;
    bus.spi_write_data_bytes_valid_i = 3'd7;
    p0 = pulses;
    bus.enable_i = 1'b1;
    cycles(150);
    check("n7_pulses", 32'(pulses - p0), 32'd32);
    check("n7_rd", bus.spi_read_data_o, 32'h12345678);
    check("n7_bv", 32'(bus.spi_read_data_bytes_valid_o), 32'd4);
    bus.enable_i = 1'b0;
    cycles(3);

    // Abort after 10 SCLK pulses of a four-byte transfer
    miso_mode = 1;
    bus.spi_write_data_i = 32'h695A0FC3;
    bus.spi_write_data_bytes_valid_i = 3'd4;
    p0 = pulses;
    bus.enable_i = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cycles(1);
      if (pulses - p0 >= 10) hit = 1'b1;
    end
    check("abort_wait", 32'(hit), 32'd1);
    rst = 1'b1;
    cycles(1);
    check("abort_ss", 32'(bus.spi_ss_o), 32'd1);
    check("abort_sclk", 32'(bus.spi_clk_o), 32'd0);
    check("abort_mosi", 32'(bus.spi_mosi_o), 32'd0);
    check("abort_rd", bus.spi_read_data_o, 32'h0);
    check("abort_bv", 32'(bus.spi_read_data_bytes_valid_o), 32'd0);
    cycles(2);

    // Clean transfer after abort
    p0 = pulses;
    rst = 1'b0;
    cycles(150);
    check("post_pulses", 32'(pulses - p0), 32'd32);
    check("post_rd", bus.spi_read_data_o, 32'hFFFFFFFF);
    check("post_bv", 32'(bus.spi_read_data_bytes_valid_o), 32'd4);
    bus.enable_i = 1'b0;
    cycles(3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
Name: spi_master_core

Overview:
- Single-channel SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
- On a request it shifts out 1-4 bytes of a 32-bit word and captures the same number of bytes from MISO.
- Presents the received bytes and their count when the transfer finishes.
- Sits between a bus-side register block and an external SPI slave; one slave select.

Parameters:
- CLK_DIV, 2, number of clk_i cycles per SCLK half-period (>=1); default gives SCLK = clk_i/4.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- enable_i  input  1  transfer request (level).
- spi_write_data_i  input  32  transmit word; valid bytes are right-aligned.
- spi_write_data_bytes_valid_i  input  3  number of bytes to transfer (N).
- spi_miso_i  input  1  serial data from slave.
- spi_mosi_o  output  1  serial data to slave.
- spi_clk_o  output  1  SCLK, idles low.
- spi_ss_o  output  1  slave select, active low.
- spi_read_data_o  output  32  received bytes, right-aligned, upper bits zero.
- spi_read_data_bytes_valid_o  output  3  bytes held in spi_read_data_o; 0 while idle-after-reset or while a transfer is running.

Behaviour:
- Reset values: spi_ss_o=1, spi_clk_o=0, spi_mosi_o=0, spi_read_data_o=0, spi_read_data_bytes_valid_o=0, FSM=IDLE. Reset mid-transfer aborts immediately with the same values.
- Byte count: N = spi_write_data_bytes_valid_i at launch. N=0 means no transfer; the FSM stays in IDLE. N>4 is clamped to 4.
- Transmit data: bits [8N-1:0] of spi_write_data_i are latched at launch and sent from bit 8N-1 down to bit 0. Inputs may change after launch with no effect.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
- IDLE:
  - On a cycle with enable_i=1 and N>=1: latch data and N, clear spi_read_data_bytes_valid_o, go to SETUP.
  - In the next cycle spi_ss_o=0 and spi_mosi_o=first bit.
- SETUP: hold for CLK_DIV cycles with SCLK low, then go to SHIFT.
- SHIFT runs for 8N SCLK periods:
  - Each SCLK half-period lasts CLK_DIV cycles.
  - On each SCLK rising edge (spi_clk_o 0->1), sample spi_miso_i into the receive shift register LSB (shift left).
  - On each falling edge, drive the next MOSI bit, except after the final bit.
  - After the 8N-th falling edge, go to HOLD with SCLK low.
- HOLD:
  - Keep spi_ss_o=0 for CLK_DIV cycles, then spi_ss_o=1.
  - In the same cycle, spi_read_data_o = received 8N bits zero-extended and spi_read_data_bytes_valid_o = N; go to DONE.
- DONE: stay while enable_i=1 (a held request gives exactly one transfer); go to IDLE when enable_i=0. Outputs persist until the next launch or reset.
- enable_i deasserted during SETUP/SHIFT/HOLD is ignored; the transfer completes.
- Timing with CLK_DIV=2, N=1: SS low 2 + 32 + 2 = 36 cycles, 8 SCLK pulses.
- Counters:
  - Bit counter is 6 bits wide (up to 32).
  - Divider counter is sized for CLK_DIV.
  - No wrap-around beyond 8N bits.
- spi_mosi_o returns to 0 when SS deasserts.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst_i for 10 cycles with enable_i=1 -> SS=1, SCLK=0, read data 0, bytes_valid_o 0, no SCLK toggles.
- One-byte: data 0x695A0FC3, N=1, MISO=1, enable_i held high 8000 ns at 50 MHz -> MOSI sends 1100_0011 over 8 SCLK pulses (12.5 MHz), SS low 36 cycles; read_data=0x000000FF, bytes_valid_o=1; no second transfer while enable_i stays high.
- Four-byte loopback: MISO tied to MOSI, data 0x695A0FC3, N=4 -> 32 SCLK pulses; read_data=0x695A0FC3, bytes_valid_o=4.
- Re-trigger: after one transfer, drop enable_i, then raise it with N=2, data 0x0000A55A, MISO=0 -> MOSI sends 0xA55A; read_data=0x00000000, bytes_valid_o=2.
- Boundaries: N=0 -> SS stays high, no SCLK. N=7 -> behaves as N=4 (32 pulses, bytes_valid_o=4).
- Abort: rst_i asserted after 10 SCLK pulses of a 4-byte transfer -> next cycle SS=1, SCLK=0, outputs 0. A new request after reset runs a full clean transfer.
